// File: rtl/bp_cce_hybrid_pending_release.sv
// bp_cce_hybrid_pending_release
//
// Completion-side producer for the hybrid CCE pending-bit write port.
// Completion events (done_*) and management clear commands (clr_*) are
// arbitrated round-robin into a small ordered queue. The queue head is issued
// to the pending stage as a decrement (done) or clear (clr) write over a
// valid/yumi interface. This block is the only one that releases addresses
// blocked by the pending stage's increment-on-issue.
//
// Parameters:
//   paddr_width_p  physical address width (BlackParrot default config: 40)
//   els_p          queue depth, power of two, >= 2
//   stall_width_p  stall counter width (only with the stats macro)
//
// Ports:
//   clk_i, reset_n_i                 clock, asynchronous active-low reset
//   done_v_i / done_ready_and_o      completion event handshake
//   done_addr_i, done_bypass_hash_i  completion payload
//   clr_v_i / clr_ready_and_o        clear command handshake
//   clr_addr_i, clr_bypass_hash_i    clear payload
//   pending_w_v_o / pending_w_yumi_i pending write handshake
//   pending_w_addr_o, pending_w_addr_bypass_hash_o
//   pending_up_o (always 0), pending_down_o, pending_clear_o
//   busy_o                           queue non-empty
//   stall_count_o                    saturating count of stalled write cycles
//
// Optional feature: define BP_CCE_HYBRID_PENDING_RELEASE_STATS_EN to add the
// stall counter and the stall_count_o port.

module bp_cce_hybrid_pending_release #(
    parameter int paddr_width_p = 40,
    parameter int els_p         = 4
`ifdef BP_CCE_HYBRID_PENDING_RELEASE_STATS_EN
   ,parameter int stall_width_p = 16
`endif
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     done_v_i,
    output logic                     done_ready_and_o,
    input  logic [paddr_width_p-1:0] done_addr_i,
    input  logic                     done_bypass_hash_i,

    input  logic                     clr_v_i,
    output logic                     clr_ready_and_o,
    input  logic [paddr_width_p-1:0] clr_addr_i,
    input  logic                     clr_bypass_hash_i,

    output logic                     pending_w_v_o,
    input  logic                     pending_w_yumi_i,
    output logic [paddr_width_p-1:0] pending_w_addr_o,
    output logic                     pending_w_addr_bypass_hash_o,
    output logic                     pending_up_o,
    output logic                     pending_down_o,
    output logic                     pending_clear_o,
    output logic                     busy_o
`ifdef BP_CCE_HYBRID_PENDING_RELEASE_STATS_EN
   ,output logic [stall_width_p-1:0] stall_count_o
`endif
);

    localparam int idx_w = $clog2(els_p);
    localparam logic [idx_w:0] ptr_one = (idx_w+1)'(1);

    typedef struct packed {
        logic [paddr_width_p-1:0] addr;
        logic                     bypass_hash;
        logic                     is_clear;
    } entry_s;

    entry_s mem_r [els_p];

    // Pointers carry one extra wrap bit above the index so full and empty
    // can be told apart when the indices match.
    logic [idx_w:0] wptr_r, rptr_r;
    logic           token_r;   // 0: done has priority, 1: clr has priority

    logic   full, empty;
    logic   done_acc, clr_acc, enq, deq;
    entry_s enq_entry, head;

    assign empty = (wptr_r == rptr_r);
    assign full  = (wptr_r[idx_w-1:0] == rptr_r[idx_w-1:0])
                 & (wptr_r[idx_w] != rptr_r[idx_w]);

    // A source is ready when it holds the token or the other source is idle.
    // Readiness never looks at the source's own valid. Reset forces both low
    // combinationally so nothing is accepted while reset_n_i is held.
    assign done_ready_and_o = reset_n_i & ~full & (~token_r | ~clr_v_i);
    assign clr_ready_and_o  = reset_n_i & ~full & ( token_r | ~done_v_i);

    assign done_acc = done_v_i & done_ready_and_o;
    assign clr_acc  = clr_v_i  & clr_ready_and_o;
    assign enq      = done_acc | clr_acc;
    // A yumi with an empty queue is a protocol error upstream; gating it here
    // keeps the pointers consistent regardless.
    assign deq      = pending_w_yumi_i & ~empty;

    always_comb begin
        enq_entry = '{addr: clr_addr_i, bypass_hash: clr_bypass_hash_i, is_clear: 1'b1};
        if (done_acc) begin
            enq_entry = '{addr: done_addr_i, bypass_hash: done_bypass_hash_i, is_clear: 1'b0};
        end
    end

    // NOTE: queue storage is deliberately left without reset; only the
    // pointers define which entries are live, so reset cost stays off the
    // wide data array.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_r[wptr_r[idx_w-1:0]] <= enq_entry;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            token_r <= 1'b0;
        end else begin
            if (enq) begin
                wptr_r  <= wptr_r + ptr_one;
                // Hand priority to the source that was not just served.
                token_r <= done_acc;
            end
            if (deq) begin
                rptr_r <= rptr_r + ptr_one;
            end
        end
    end

    assign head = mem_r[rptr_r[idx_w-1:0]];

    // Valid and the write kind derive from the asynchronously reset pointers,
    // so they drop immediately when reset asserts.
    assign pending_w_v_o                = ~empty;
    assign busy_o                       = ~empty;
    assign pending_w_addr_o             = head.addr;
    assign pending_w_addr_bypass_hash_o = head.bypass_hash;
    assign pending_up_o                 = 1'b0;
    assign pending_down_o               = ~empty & ~head.is_clear;
    assign pending_clear_o              = ~empty &  head.is_clear;

`ifdef BP_CCE_HYBRID_PENDING_RELEASE_STATS_EN
    logic [stall_width_p-1:0] stall_count_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_count_r <= '0;
        end else if (pending_w_v_o && !pending_w_yumi_i && !(&stall_count_r)) begin
            stall_count_r <= stall_count_r + 1'b1;
        end
    end

    assign stall_count_o = stall_count_r;
`endif

endmodule

// File: tb/tb_bp_cce_hybrid_pending_release.sv
// Directed self-checking bench for bp_cce_hybrid_pending_release.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge (or mid-cycle for asynchronous reset checks).

module tb_bp_cce_hybrid_pending_release;

    localparam int AW = 40;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b1;
    logic          done_v_i = 1'b0, done_bypass_hash_i = 1'b0;
    logic [AW-1:0] done_addr_i = '0;
    logic          clr_v_i = 1'b0, clr_bypass_hash_i = 1'b0;
    logic [AW-1:0] clr_addr_i = '0;
    logic          done_ready_and_o, clr_ready_and_o;
    logic          pending_w_v_o, pending_w_yumi_i;
    logic [AW-1:0] pending_w_addr_o;
    logic          pending_w_addr_bypass_hash_o;
    logic          pending_up_o, pending_down_o, pending_clear_o, busy_o;
`ifdef BP_CCE_HYBRID_PENDING_RELEASE_STATS_EN
    logic [15:0]   stall_count_o;
`endif

    logic yumi_force = 1'b0;
    logic auto_yumi  = 1'b0;   // models a pending stage with yumi tied high
    assign pending_w_yumi_i = yumi_force | (auto_yumi & pending_w_v_o);

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          clr;
    } wr_t;
    wr_t rx_q[$];

    bp_cce_hybrid_pending_release #(.paddr_width_p(AW), .els_p(4)) dut (
        .clk_i                        (clk_i),
        .reset_n_i                    (reset_n_i),
        .done_v_i                     (done_v_i),
        .done_ready_and_o             (done_ready_and_o),
        .done_addr_i                  (done_addr_i),
        .done_bypass_hash_i           (done_bypass_hash_i),
        .clr_v_i                      (clr_v_i),
        .clr_ready_and_o              (clr_ready_and_o),
        .clr_addr_i                   (clr_addr_i),
        .clr_bypass_hash_i            (clr_bypass_hash_i),
        .pending_w_v_o                (pending_w_v_o),
        .pending_w_yumi_i             (pending_w_yumi_i),
        .pending_w_addr_o             (pending_w_addr_o),
        .pending_w_addr_bypass_hash_o (pending_w_addr_bypass_hash_o),
        .pending_up_o                 (pending_up_o),
        .pending_down_o               (pending_down_o),
        .pending_clear_o              (pending_clear_o),
        .busy_o                       (busy_o)
`ifdef BP_CCE_HYBRID_PENDING_RELEASE_STATS_EN
       ,.stall_count_o                (stall_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Record every write the pending stage consumes, and flag any yumi
    // offered without a valid write.
    always @(negedge clk_i) begin
        if (reset_n_i && pending_w_yumi_i) begin
            if (!pending_w_v_o) begin
                n_err++;
                $display("FAIL yumi_without_valid: t=%0t yumi=1 v=%0b required v=1", $time, pending_w_v_o);
            end else begin
                rx_q.push_back('{addr: pending_w_addr_o, clr: pending_clear_o});
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        done_v_i   = 1'b0;
        clr_v_i    = 1'b0;
        yumi_force = 1'b0;
        auto_yumi  = 1'b0;
        reset_n_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();
        rx_q.delete();
    endtask

    task automatic test_reset();
        #2;
        done_v_i  = 1'b1;
        clr_v_i   = 1'b1;
        reset_n_i = 1'b0;
        #1;
        n_cmp++;
        if (pending_w_v_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: v=%0b busy=%0b required 0/0", pending_w_v_o, busy_o);
        end
        n_cmp++;
        if (done_ready_and_o !== 1'b0 || clr_ready_and_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_readys: done_rdy=%0b clr_rdy=%0b required 0/0", done_ready_and_o, clr_ready_and_o);
        end
        do_reset();
        @(negedge clk_i);
        n_cmp++;
        if (done_ready_and_o !== 1'b1 || clr_ready_and_o !== 1'b1 || pending_w_v_o !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: done_rdy=%0b clr_rdy=%0b v=%0b required 1/1/0",
                     done_ready_and_o, clr_ready_and_o, pending_w_v_o);
        end
        tick();
    endtask

    task automatic test_single_done();
        do_reset();
        auto_yumi   = 1'b1;
        done_v_i    = 1'b1;
        done_addr_i = 40'h00_8000_0040;
        @(negedge clk_i);
        n_cmp++;
        if (done_ready_and_o !== 1'b1 || pending_w_v_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_accept: done_rdy=%0b v=%0b required 1/0", done_ready_and_o, pending_w_v_o);
        end
        tick();
        done_v_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (pending_w_v_o !== 1'b1 || pending_down_o !== 1'b1 || pending_clear_o !== 1'b0 ||
            pending_up_o !== 1'b0 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL single_kind: v=%0b down=%0b clr=%0b up=%0b busy=%0b required 1/1/0/0/1",
                     pending_w_v_o, pending_down_o, pending_clear_o, pending_up_o, busy_o);
        end
        n_cmp++;
        if (pending_w_addr_o !== 40'h00_8000_0040) begin
            n_err++;
            $display("FAIL single_addr: got %h required %h", pending_w_addr_o, 40'h00_8000_0040);
        end
        tick();
        @(negedge clk_i);
        n_cmp++;
        if (busy_o !== 1'b0 || pending_w_v_o !== 1'b0 || pending_down_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_drained: busy=%0b v=%0b down=%0b required 0/0/0", busy_o, pending_w_v_o, pending_down_o);
        end
        n_cmp++;
        if (rx_q.size() != 1) begin
            n_err++;
            $display("FAIL single_count: got %0d writes required 1", rx_q.size());
        end
        auto_yumi = 1'b0;
    endtask

    task automatic test_round_robin();
        wr_t exp [4];
        do_reset();
        done_v_i           = 1'b1;
        clr_v_i            = 1'b1;
        done_bypass_hash_i = 1'b0;
        clr_bypass_hash_i  = 1'b1;
        exp[0] = '{addr: 40'h1000, clr: 1'b0};
        exp[1] = '{addr: 40'h2040, clr: 1'b1};
        exp[2] = '{addr: 40'h1080, clr: 1'b0};
        exp[3] = '{addr: 40'h20C0, clr: 1'b1};
        for (int k = 0; k < 4; k++) begin
            done_addr_i = 40'h1000 + 40'(k * 'h40);
            clr_addr_i  = 40'h2000 + 40'(k * 'h40);
            @(negedge clk_i);
            n_cmp++;
            if (done_ready_and_o !== ((k % 2) == 0) || clr_ready_and_o !== ((k % 2) == 1)) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: done_rdy=%0b clr_rdy=%0b required %0b/%0b",
                         k, done_ready_and_o, clr_ready_and_o, (k % 2) == 0, (k % 2) == 1);
            end
            tick();
        end
        @(negedge clk_i);
        n_cmp++;
        if (done_ready_and_o !== 1'b0 || clr_ready_and_o !== 1'b0) begin
            n_err++;
            $display("FAIL rr_full_readys: done_rdy=%0b clr_rdy=%0b required 0/0", done_ready_and_o, clr_ready_and_o);
        end
        tick();
        done_v_i   = 1'b0;
        clr_v_i    = 1'b0;
        yumi_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (pending_w_v_o !== 1'b1 || pending_w_addr_o !== exp[i].addr ||
                pending_clear_o !== exp[i].clr || pending_down_o !== !exp[i].clr ||
                pending_w_addr_bypass_hash_o !== exp[i].clr) begin
                n_err++;
                $display("FAIL rr_drain[%0d]: v=%0b addr=%h clr=%0b down=%0b bh=%0b required 1/%h/%0b/%0b/%0b",
                         i, pending_w_v_o, pending_w_addr_o, pending_clear_o, pending_down_o,
                         pending_w_addr_bypass_hash_o, exp[i].addr, exp[i].clr, !exp[i].clr, exp[i].clr);
            end
            tick();
        end
        yumi_force = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (pending_w_v_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL rr_empty: v=%0b busy=%0b required 0/0", pending_w_v_o, busy_o);
        end
        tick();
    endtask

    task automatic test_full_wrap();
        int k;
        int budget;
        do_reset();
        done_v_i = 1'b1;
        for (k = 0; k < 4; k++) begin
            done_addr_i = 40'h3000 + 40'(k * 'h40);
            tick();
        end
        // Full: pop once while offering a fifth entry in the same cycle.
        done_addr_i = 40'h3000 + 40'(4 * 'h40);
        yumi_force  = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (done_ready_and_o !== 1'b0 || clr_ready_and_o !== 1'b0 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_yumi_readys: done_rdy=%0b clr_rdy=%0b busy=%0b required 0/0/1",
                     done_ready_and_o, clr_ready_and_o, busy_o);
        end
        tick();
        yumi_force = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (done_ready_and_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_freed_ready: done_rdy=%0b required 1", done_ready_and_o);
        end
        tick();
        auto_yumi = 1'b1;
        k = 5;
        budget = 40;
        while (k < 9 && budget > 0) begin
            logic acc;
            done_addr_i = 40'h3000 + 40'(k * 'h40);
            @(negedge clk_i);
            acc = done_ready_and_o;
            tick();
            if (acc) k++;
            budget--;
        end
        done_v_i = 1'b0;
        budget = 20;
        while (busy_o && budget > 0) begin
            tick();
            budget--;
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_drain_timeout: busy=%0b required 0 (enqueued %0d of 9)", busy_o, k);
        end
        n_cmp++;
        if (rx_q.size() != 9) begin
            n_err++;
            $display("FAIL wrap_count: got %0d writes required 9", rx_q.size());
        end
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            logic [AW-1:0] want;
            want = 40'h3000 + 40'(i * 'h40);
            n_cmp++;
            if (rx_q[i].addr !== want || rx_q[i].clr !== 1'b0) begin
                n_err++;
                $display("FAIL wrap_order[%0d]: addr=%h clr=%0b required %h/0", i, rx_q[i].addr, rx_q[i].clr, want);
            end
        end
        auto_yumi = 1'b0;
    endtask

    task automatic test_stall_hold();
        do_reset();
        done_v_i    = 1'b1;
        done_addr_i = 40'h55_0000_0100;
        tick();
        done_v_i    = 1'b0;
        done_addr_i = 40'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (pending_w_v_o !== 1'b1 || pending_w_addr_o !== 40'h55_0000_0100 ||
                pending_down_o !== 1'b1 || pending_clear_o !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: v=%0b addr=%h down=%0b clr=%0b required 1/%h/1/0",
                         i, pending_w_v_o, pending_w_addr_o, pending_down_o, pending_clear_o, 40'h55_0000_0100);
            end
            tick();
        end
`ifdef BP_CCE_HYBRID_PENDING_RELEASE_STATS_EN
        n_cmp++;
        if (stall_count_o !== 16'd5) begin
            n_err++;
            $display("FAIL stall_count: got %0d required 5", stall_count_o);
        end
`endif
        yumi_force = 1'b1;
        tick();
        yumi_force = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (pending_w_v_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: v=%0b busy=%0b required 0/0", pending_w_v_o, busy_o);
        end
`ifdef BP_CCE_HYBRID_PENDING_RELEASE_STATS_EN
        n_cmp++;
        if (stall_count_o !== 16'd5) begin
            n_err++;
            $display("FAIL stall_count_after: got %0d required 5", stall_count_o);
        end
`endif
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        done_v_i = 1'b1;
        clr_v_i  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            done_addr_i = 40'h4000 + 40'(k * 'h40);
            clr_addr_i  = 40'h5000 + 40'(k * 'h40);
            tick();
        end
        done_v_i = 1'b0;
        clr_v_i  = 1'b0;
        #2;
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_prefill_busy: busy=%0b required 1", busy_o);
        end
        reset_n_i = 1'b0;
        #1;
        n_cmp++;
        if (pending_w_v_o !== 1'b0 || busy_o !== 1'b0 || pending_down_o !== 1'b0 || pending_clear_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_async: v=%0b busy=%0b down=%0b clr=%0b required 0/0/0/0",
                     pending_w_v_o, busy_o, pending_down_o, pending_clear_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();
        done_v_i    = 1'b1;
        clr_v_i     = 1'b1;
        done_addr_i = 40'h6600;
        clr_addr_i  = 40'h7700;
        @(negedge clk_i);
        n_cmp++;
        if (pending_w_v_o !== 1'b0 || done_ready_and_o !== 1'b1 || clr_ready_and_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_after_release: v=%0b done_rdy=%0b clr_rdy=%0b required 0/1/0",
                     pending_w_v_o, done_ready_and_o, clr_ready_and_o);
        end
        tick();
        done_v_i = 1'b0;
        clr_v_i  = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (pending_w_v_o !== 1'b1 || pending_w_addr_o !== 40'h6600 || pending_down_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_fresh_head: v=%0b addr=%h down=%0b required 1/%h/1",
                     pending_w_v_o, pending_w_addr_o, pending_down_o, 40'h6600);
        end
        tick();
        yumi_force = 1'b1;
        tick();
        yumi_force = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_no_stale: busy=%0b required 0", busy_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_done();
        test_round_robin();
        test_full_wrap();
        test_stall_hold();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
